lcd_fb_arbiter: RTL and testbench



---
 rtl/lcd_fb_pkg.sv | 17 +
 rtl/lcd_fb_starve_cnt.sv | 33 +++
 rtl/lcd_fb_arbiter.sv | 105 ++++++++++
 tb/tb_lcd_fb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_fb_pkg.sv
// Shared constants and FSM encodings for the LCD frame-buffer arbiter.
package lcd_fb_pkg;

  localparam int FB_W_WORD    = 19;
  localparam int FB_W_PIX     = 24;
  localparam int FB_MAX_STALL = 4;
  localparam int FB_W_STALL   = 3;

  // Records which access was issued to the BRAM in the previous cycle
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DISP   = 2'd1,
    ST_BUS_RD = 2'd2,
    ST_BUS_WR = 2'd3
  } fb_arb_state_t;

endpackage

// File: rtl/lcd_fb_starve_cnt.sv
// Saturating bus starvation counter; force_bus tells the arbiter the bus
// has waited long enough and must win the next arbitration.
module lcd_fb_starve_cnt
  import lcd_fb_pkg::*;
#(
  parameter int MAX_STALL = FB_MAX_STALL,
  parameter int W_STALL   = FB_W_STALL
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic bus_req,
  input  logic bus_gnt,
  output logic force_bus
);

  localparam logic [W_STALL-1:0] STALL_LIMIT = W_STALL'(MAX_STALL);

  logic [W_STALL-1:0] starve;

  // Count consecutive denied bus cycles, clear on grant or withdrawn request
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      starve <= '0;
    end else if (!bus_req || bus_gnt) begin
      starve <= '0;
    end else if (starve != STALL_LIMIT) begin
      starve <= starve + 1'b1;
    end
  end

  assign force_bus = (starve == STALL_LIMIT);

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Single-port frame-buffer arbiter between the AHB load path and scan-out.
// Scan-out wins by default; the starvation counter forces a bus slot.
// Optional macro LCD_FB_ARB_STATS_EN adds the stat_bus_stall counter port.
module lcd_fb_arbiter
  import lcd_fb_pkg::*;
#(
  parameter int W_WORD    = FB_W_WORD,
  parameter int W_PIX     = FB_W_PIX,
  parameter int MAX_STALL = FB_MAX_STALL,
  parameter int W_STALL   = FB_W_STALL
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 bus_req,
  input  logic                 bus_we,
  input  logic [W_WORD-1:0]    bus_addr,
  input  logic [W_PIX-1:0]     bus_wdata,
  output logic                 bus_gnt,
  output logic                 bus_rvalid,
  output logic [W_PIX-1:0]     bus_rdata,
  input  logic                 disp_req,
  input  logic [W_WORD-1:0]    disp_addr,
  output logic                 disp_gnt,
  output logic                 disp_rvalid,
  output logic [2*W_PIX-1:0]   disp_rdata,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic [W_WORD-1:0]    bram_addr,
  output logic [W_PIX-1:0]     bram_din,
  input  logic [W_PIX-1:0]     bram_dout,
  input  logic [2*W_PIX-1:0]   bram_dout_dual
`ifdef LCD_FB_ARB_STATS_EN
  ,
  output logic [15:0]          stat_bus_stall
`endif
);

  // Scan-out always reads pixel pairs, so the low address bit is dropped
  localparam logic [W_WORD-1:0] PAIR_MASK = {{(W_WORD-1){1'b1}}, 1'b0};

  fb_arb_state_t     state;
  logic              force_bus;
  logic [W_WORD-1:0] disp_addr_even;

  lcd_fb_starve_cnt #(
    .MAX_STALL (MAX_STALL),
    .W_STALL   (W_STALL)
  ) u_starve (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .force_bus (force_bus)
  );

  // Grants are held off while reset is asserted so every output reads 0
  assign bus_gnt  = !HRESET && bus_req && (!disp_req || force_bus);
  assign disp_gnt = !HRESET && disp_req && !bus_gnt;

  assign disp_addr_even = disp_addr & PAIR_MASK;

  assign bram_en  = bus_gnt || disp_gnt;
  assign bram_we  = bus_gnt && bus_we;
  assign bram_din = HRESET ? '0 : bus_wdata;

  // Drive the BRAM address from whichever requester holds the grant
  always_comb begin
    bram_addr = '0;
    if (bus_gnt) begin
      bram_addr = bus_addr;
    end else if (disp_gnt) begin
      bram_addr = disp_addr_even;
    end
  end

  // Remember the access issued this cycle so its read data can be tagged next cycle
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else if (disp_gnt) begin
      state <= ST_DISP;
    end else if (bus_gnt) begin
      state <= bus_we ? ST_BUS_WR : ST_BUS_RD;
    end else begin
      state <= ST_IDLE;
    end
  end

  assign disp_rvalid = !HRESET && (state == ST_DISP);
  assign bus_rvalid  = !HRESET && (state == ST_BUS_RD);
  assign disp_rdata  = disp_rvalid ? bram_dout_dual : '0;
  assign bus_rdata   = bus_rvalid ? bram_dout : '0;

`ifdef LCD_FB_ARB_STATS_EN
  // Saturating count of every cycle the bus asked and was turned away
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      stat_bus_stall <= '0;
    end else if (bus_req && !bus_gnt && (stat_bus_stall != 16'hFFFF)) begin
      stat_bus_stall <= stat_bus_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Self-checking bench for lcd_fb_arbiter with a small 1-cycle BRAM model.
// Build with LCD_FB_ARB_STATS_EN to also exercise stat_bus_stall.
module tb_lcd_fb_arbiter;
  import lcd_fb_pkg::*;

  logic        HCLK;
  logic        HRESET;
  logic        bus_req, bus_we;
  logic [18:0] bus_addr;
  logic [23:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [23:0] bus_rdata;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        disp_gnt, disp_rvalid;
  logic [47:0] disp_rdata;
  logic        bram_en, bram_we;
  logic [18:0] bram_addr;
  logic [23:0] bram_din;
  logic [23:0] bram_dout;
  logic [47:0] bram_dout_dual;
`ifdef LCD_FB_ARB_STATS_EN
  logic [15:0] stat_bus_stall;
`endif

  logic        preload;
  logic [23:0] mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;

  lcd_fb_arbiter dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_gnt        (bus_gnt),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rvalid    (disp_rvalid),
    .disp_rdata     (disp_rdata),
    .bram_en        (bram_en),
    .bram_we        (bram_we),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .bram_dout      (bram_dout),
    .bram_dout_dual (bram_dout_dual)
`ifdef LCD_FB_ARB_STATS_EN
    ,
    .stat_bus_stall (stat_bus_stall)
`endif
  );

  // Free-running clock
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // BRAM model: 256 words aliased on the low address byte, 1-cycle read latency
  always @(posedge HCLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 24'h100000 + 24'(i);
      bram_dout      <= '0;
      bram_dout_dual <= '0;
    end else if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr[7:0]] <= bram_din;
      end else begin
        bram_dout      <= mem[bram_addr[7:0]];
        bram_dout_dual <= {mem[bram_addr[7:0] + 8'd1], mem[bram_addr[7:0]]};
      end
    end
  end

  typedef struct {
    logic        bus_req;
    logic        bus_we;
    logic [18:0] bus_addr;
    logic [23:0] bus_wdata;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic        e_bus_gnt;
    logic        e_disp_gnt;
    logic        e_bram_we;
    logic [18:0] e_bram_addr;
    logic        e_bus_rvalid;
    logic [23:0] e_bus_rdata;
    logic        e_disp_rvalid;
    logic [47:0] e_disp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic b_req, input logic b_we,
                               input logic [18:0] b_addr, input logic [23:0] b_wdata,
                               input logic d_req, input logic [18:0] d_addr);
    bus_req   = b_req;
    bus_we    = b_we;
    bus_addr  = b_addr;
    bus_wdata = b_wdata;
    disp_req  = d_req;
    disp_addr = d_addr;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    HRESET  = 1'b1;
    preload = 1'b1;
    applyStimulus(1'b1, 1'b1, 19'h00005, 24'h555555, 1'b1, 19'h00007);
    step();
    #2;
    // Reset state: requests present but nothing may be granted
    checkOutput("rst_bus_gnt", 64'(bus_gnt), 64'd0);
    checkOutput("rst_disp_gnt", 64'(disp_gnt), 64'd0);
    checkOutput("rst_bram_en", 64'(bram_en), 64'd0);
    checkOutput("rst_bram_din", 64'(bram_din), 64'd0);
    checkOutput("rst_state", 64'(dut.state), 64'(ST_IDLE));
    step();
    preload = 1'b0;
    HRESET  = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #2;
    checkOutput("rel_bus_rvalid", 64'(bus_rvalid), 64'd0);
    checkOutput("rel_disp_rvalid", 64'(disp_rvalid), 64'd0);

    // Single-shot vectors, each followed by an idle cycle that checks the return
    vecs[0] = '{1'b1, 1'b1, 19'h00010, 24'hA1B2C3, 1'b0, 19'h0,
                1'b1, 1'b0, 1'b1, 19'h00010, 1'b0, 24'h0, 1'b0, 48'h0};
    vecs[1] = '{1'b1, 1'b0, 19'h00010, 24'h000000, 1'b0, 19'h0,
                1'b1, 1'b0, 1'b0, 19'h00010, 1'b1, 24'hA1B2C3, 1'b0, 48'h0};
    vecs[2] = '{1'b0, 1'b0, 19'h0, 24'h0, 1'b1, 19'h00011,
                1'b0, 1'b1, 1'b0, 19'h00010, 1'b0, 24'h0, 1'b1, {24'h100011, 24'hA1B2C3}};
    vecs[3] = '{1'b1, 1'b0, 19'h00020, 24'h0, 1'b1, 19'h00031,
                1'b0, 1'b1, 1'b0, 19'h00030, 1'b0, 24'h0, 1'b1, {24'h100031, 24'h100030}};
    vecs[4] = '{1'b0, 1'b0, 19'h0, 24'h0, 1'b0, 19'h0,
                1'b0, 1'b0, 1'b0, 19'h0, 1'b0, 24'h0, 1'b0, 48'h0};
    vecs[5] = '{1'b1, 1'b1, 19'h00040, 24'hDEAD01, 1'b1, 19'h00042,
                1'b0, 1'b1, 1'b0, 19'h00042, 1'b0, 24'h0, 1'b1, {24'h100043, 24'h100042}};
    vecs[6] = '{1'b0, 1'b0, 19'h0, 24'h0, 1'b1, 19'h7FFFF,
                1'b0, 1'b1, 1'b0, 19'h7FFFE, 1'b0, 24'h0, 1'b1, {24'h1000FF, 24'h1000FE}};
    vecs[7] = '{1'b1, 1'b1, 19'h7FFFF, 24'h123456, 1'b0, 19'h0,
                1'b1, 1'b0, 1'b1, 19'h7FFFF, 1'b0, 24'h0, 1'b0, 48'h0};
    vecs[8] = '{1'b1, 1'b0, 19'h7FFFF, 24'h0, 1'b0, 19'h0,
                1'b1, 1'b0, 1'b0, 19'h7FFFF, 1'b1, 24'h123456, 1'b0, 48'h0};

    for (int i = 0; i < 9; i++) begin
      step();
      applyStimulus(vecs[i].bus_req, vecs[i].bus_we, vecs[i].bus_addr, vecs[i].bus_wdata,
                    vecs[i].disp_req, vecs[i].disp_addr);
      #2;
      checkOutput($sformatf("v%0d_bus_gnt", i), 64'(bus_gnt), 64'(vecs[i].e_bus_gnt));
      checkOutput($sformatf("v%0d_disp_gnt", i), 64'(disp_gnt), 64'(vecs[i].e_disp_gnt));
      checkOutput($sformatf("v%0d_bram_en", i), 64'(bram_en),
                  64'(vecs[i].e_bus_gnt | vecs[i].e_disp_gnt));
      checkOutput($sformatf("v%0d_bram_we", i), 64'(bram_we), 64'(vecs[i].e_bram_we));
      checkOutput($sformatf("v%0d_bram_addr", i), 64'(bram_addr), 64'(vecs[i].e_bram_addr));
      checkOutput($sformatf("v%0d_bram_din", i), 64'(bram_din), 64'(vecs[i].bus_wdata));
      step();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
      #2;
      checkOutput($sformatf("v%0d_bus_rvalid", i), 64'(bus_rvalid), 64'(vecs[i].e_bus_rvalid));
      checkOutput($sformatf("v%0d_bus_rdata", i), 64'(bus_rdata), 64'(vecs[i].e_bus_rdata));
      checkOutput($sformatf("v%0d_disp_rvalid", i), 64'(disp_rvalid), 64'(vecs[i].e_disp_rvalid));
      checkOutput($sformatf("v%0d_disp_rdata", i), 64'(disp_rdata), 64'(vecs[i].e_disp_rdata));
    end

    // Reset asserted the cycle after a display grant discards the return
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 19'h00050);
    #2;
    checkOutput("rr_disp_gnt", 64'(disp_gnt), 64'd1);
    step();
    HRESET = 1'b1;
    #2;
    checkOutput("rr_disp_rvalid_in_rst", 64'(disp_rvalid), 64'd0);
    checkOutput("rr_disp_gnt_in_rst", 64'(disp_gnt), 64'd0);
    checkOutput("rr_bram_en_in_rst", 64'(bram_en), 64'd0);
    step();
    HRESET = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #2;
    checkOutput("rr_disp_rvalid_after", 64'(disp_rvalid), 64'd0);
    checkOutput("rr_state", 64'(dut.state), 64'(ST_IDLE));
    checkOutput("rr_starve", 64'(dut.u_starve.starve), 64'd0);
`ifdef LCD_FB_ARB_STATS_EN
    checkOutput("rr_stat", 64'(stat_bus_stall), 64'd0);
`endif

    // Starvation: disp held continuously, bus held until its forced grant on cycle 5
    for (int c = 1; c <= 6; c++) begin
      step();
      applyStimulus(c <= 5, 1'b0, 19'h00020, 24'h0, 1'b1, 19'h00030);
      #2;
      checkOutput($sformatf("sv_c%0d_bus_gnt", c), 64'(bus_gnt), 64'(c == 5));
      checkOutput($sformatf("sv_c%0d_disp_gnt", c), 64'(disp_gnt), 64'(c != 5));
      if (c == 5) begin
        checkOutput("sv_c5_bram_addr", 64'(bram_addr), 64'h00020);
      end
      if (c == 6) begin
        checkOutput("sv_c6_bus_rvalid", 64'(bus_rvalid), 64'd1);
        checkOutput("sv_c6_bus_rdata", 64'(bus_rdata), 64'h100020);
        checkOutput("sv_c6_bram_addr", 64'(bram_addr), 64'h00030);
      end
    end
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #2;
    checkOutput("sv_end_disp_rvalid", 64'(disp_rvalid), 64'd1);
    checkOutput("sv_end_disp_rdata", 64'(disp_rdata), {16'h0, 24'h100031, 24'h100030});
`ifdef LCD_FB_ARB_STATS_EN
    checkOutput("sv_stat_bus_stall", 64'(stat_bus_stall), 64'd4);
`endif

    // Bus request withdrawn before being granted clears the starvation count
    for (int c = 1; c <= 2; c++) begin
      step();
      applyStimulus(1'b1, 1'b0, 19'h00060, 24'h0, 1'b1, 19'h00060);
      #2;
      checkOutput($sformatf("dr_c%0d_bus_gnt", c), 64'(bus_gnt), 64'd0);
    end
    step();
    applyStimulus(1'b0, 1'b0, 19'h00060, 24'h0, 1'b1, 19'h00060);
    #2;
    checkOutput("dr_starve_before_drop", 64'(dut.u_starve.starve), 64'd2);
    checkOutput("dr_bus_gnt_dropped", 64'(bus_gnt), 64'd0);
    checkOutput("dr_bram_we_dropped", 64'(bram_we), 64'd0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #2;
    checkOutput("dr_starve_cleared", 64'(dut.u_starve.starve), 64'd0);
    checkOutput("dr_bus_rvalid", 64'(bus_rvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
